// File: rtl/breakout_pkg.sv
// Shared colour constants, pixel type and renderer FSM states for the Breakout display path.
package breakout_pkg;

    typedef logic [23:0] rgb_t;

    localparam rgb_t BLACK  = 24'h000000;
    localparam rgb_t WHITE  = 24'hFFFFFF;
    localparam rgb_t RED    = 24'hFF0000;
    localparam rgb_t YELLOW = 24'hFFFF00;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/brick_flash_timer.sv
// Per-brick destruction flash timer: loads on a hit-bit rise, counts down on frame ticks.
module brick_flash_timer #(
    parameter int unsigned FLASH_FRAMES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic hit,
    input  logic frame_tick,
    output logic flashing
);

    logic [7:0] cnt_q, cnt_d;
    logic       hit_q, hit_d;
    logic       flashing_q, flashing_d;

    // Load beats tick; a level drop clears any flash in progress.
    always_comb begin
        cnt_d      = cnt_q;
        hit_d      = hit;
        if (hit && !hit_q) begin
            cnt_d = 8'(FLASH_FRAMES);
        end else if (!hit && hit_q) begin
            cnt_d = 8'd0;
        end else if (frame_tick && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
        flashing_d = (cnt_d != 8'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= 8'd0;
            hit_q      <= 1'b0;
            flashing_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            hit_q      <= hit_d;
            flashing_q <= flashing_d;
        end
    end

    assign flashing = flashing_q;

endmodule

// File: rtl/brick_field_renderer.sv
// Two-stage pixel colour generator: paddle > ball > brick grid > background.
// Optional destruction flash animation enabled by defining BRICK_FLASH_EN.
module brick_field_renderer
    import breakout_pkg::*;
#(
    parameter int unsigned COORD_W      = 10,
    parameter int unsigned ROWS         = 3,
    parameter int unsigned COLS         = 8,
    parameter int unsigned BRICK_W      = 80,
    parameter int unsigned BRICK_H      = 50,
    parameter int unsigned FIELD_X0     = 0,
    parameter int unsigned FIELD_Y0     = 0,
    parameter int unsigned PADDLE_W     = 160,
    parameter int unsigned PADDLE_H     = 10,
    parameter int unsigned BALL_R       = 3,
    parameter int unsigned FLASH_FRAMES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   pix_valid,
    input  logic [COORD_W-1:0]     x,
    input  logic [COORD_W-1:0]     y,
    input  logic [COORD_W-1:0]     ballx,
    input  logic [COORD_W-1:0]     bally,
    input  logic [COORD_W-1:0]     paddlex,
    input  logic [COORD_W-1:0]     paddley,
    input  logic [ROWS*COLS-1:0]   hit_mask,
    output logic [23:0]            color,
    output logic                   color_valid
);

    localparam int unsigned CW  = COORD_W + 2;
    localparam int unsigned NB  = ROWS * COLS;
    localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CLW = (COLS > 1) ? $clog2(COLS) : 1;

    if ((FLASH_FRAMES < 1) || (FLASH_FRAMES > 255)) begin : g_bad_flash_frames
        $error("FLASH_FRAMES must lie in 1..255");
    end

    state_e state_q, state_d;

    logic           valid1_q, valid1_d;
    logic           run1_q, run1_d;
    logic           pad1_q, pad1_d;
    logic           ball1_q, ball1_d;
    logic           brick1_q, brick1_d;
    logic           flash1_q, flash1_d;
    logic [RW-1:0]  row1_q, row1_d;
    logic [CLW-1:0] col1_q, col1_d;
    rgb_t           color_q, color_d;
    logic           color_valid_q, color_valid_d;

    logic [CW-1:0]   xe, ye, bxe, bye, pxe, pye;
    logic [ROWS-1:0] row_hit;
    logic [COLS-1:0] col_hit;
    logic [NB-1:0]   brick_flash;
    logic [NB-1:0]   cell_on;

    assign xe  = CW'(x);
    assign ye  = CW'(y);
    assign bxe = CW'(ballx);
    assign bye = CW'(bally);
    assign pxe = CW'(paddlex);
    assign pye = CW'(paddley);

    for (genvar c = 0; c < COLS; c++) begin : g_col
        assign col_hit[c] = (xe >= CW'(FIELD_X0 + c * BRICK_W)) &&
                            (xe <  CW'(FIELD_X0 + (c + 1) * BRICK_W));
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign row_hit[r] = (ye >= CW'(FIELD_Y0 + r * BRICK_H)) &&
                            (ye <  CW'(FIELD_Y0 + (r + 1) * BRICK_H));
    end

    // A cell is visible while intact, or while its destruction flash runs.
    for (genvar r = 0; r < ROWS; r++) begin : g_cell_r
        for (genvar c = 0; c < COLS; c++) begin : g_cell_c
            assign cell_on[r*COLS+c] = row_hit[r] && col_hit[c] &&
                                       (!hit_mask[r*COLS+c] || brick_flash[r*COLS+c]);
        end
    end

`ifdef BRICK_FLASH_EN
    logic frame_tick;
    assign frame_tick = pix_valid && (x == '0) && (y == '0);

    for (genvar i = 0; i < NB; i++) begin : g_flash
        brick_flash_timer #(
            .FLASH_FRAMES (FLASH_FRAMES)
        ) u_timer (
            .clk        (clk),
            .rst        (rst),
            .hit        (hit_mask[i]),
            .frame_tick (frame_tick),
            .flashing   (brick_flash[i])
        );
    end
`else
    assign brick_flash = '0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!start) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Stage 1: region hits and the (single, cells are disjoint) active brick index.
    always_comb begin
        valid1_d = pix_valid;
        run1_d   = (state_q == RUN);
        pad1_d   = (xe >= pxe) && (xe < pxe + CW'(PADDLE_W)) &&
                   (ye >= pye) && (ye < pye + CW'(PADDLE_H));
        ball1_d  = (xe < bxe + CW'(BALL_R)) && (bxe < xe + CW'(BALL_R)) &&
                   (ye < bye + CW'(BALL_R)) && (bye < ye + CW'(BALL_R));
        brick1_d = 1'b0;
        flash1_d = 1'b0;
        row1_d   = '0;
        col1_d   = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (cell_on[r*COLS+c]) begin
                    brick1_d = 1'b1;
                    flash1_d = brick_flash[r*COLS+c];
                    row1_d   = RW'(r);
                    col1_d   = CLW'(c);
                end
            end
        end
    end

    // Stage 2: colour resolve; black whenever the pixel entered before RUN.
    always_comb begin
        color_d       = BLACK;
        color_valid_d = valid1_q;
        if (run1_q) begin
            if (pad1_q || ball1_q) begin
                color_d = WHITE;
            end else if (brick1_q) begin
                if (flash1_q)                  color_d = YELLOW;
                else if (row1_q[0] ^ col1_q[0]) color_d = WHITE;
                else                           color_d = RED;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            valid1_q      <= 1'b0;
            run1_q        <= 1'b0;
            pad1_q        <= 1'b0;
            ball1_q       <= 1'b0;
            brick1_q      <= 1'b0;
            flash1_q      <= 1'b0;
            row1_q        <= '0;
            col1_q        <= '0;
            color_q       <= BLACK;
            color_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            valid1_q      <= valid1_d;
            run1_q        <= run1_d;
            pad1_q        <= pad1_d;
            ball1_q       <= ball1_d;
            brick1_q      <= brick1_d;
            flash1_q      <= flash1_d;
            row1_q        <= row1_d;
            col1_q        <= col1_d;
            color_q       <= color_d;
            color_valid_q <= color_valid_d;
        end
    end

    assign color       = color_q;
    assign color_valid = color_valid_q;

endmodule

// File: tb/tb_brick_field_renderer.sv
// Randomised and directed check of brick_field_renderer against a pixel-level reference model.
module tb_brick_field_renderer;

    localparam int unsigned CW   = 10;
    localparam int unsigned ROWS = 3;
    localparam int unsigned COLS = 8;
    localparam int unsigned NB   = ROWS * COLS;
    localparam int          BW   = 80;
    localparam int          BH   = 50;
    localparam int          FX0  = 0;
    localparam int          FY0  = 0;
    localparam int          PW   = 160;
    localparam int          PH   = 10;
    localparam int          BR   = 3;
    localparam int          FF   = 2;

`ifdef BRICK_FLASH_EN
    localparam logic [23:0] FLASH_EXP = 24'hFFFF00;
`else
    localparam logic [23:0] FLASH_EXP = 24'h000000;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          pix_valid;
    logic [CW-1:0] x, y, ballx, bally, paddlex, paddley;
    logic [NB-1:0] hit_mask;
    logic [23:0]   color;
    logic          color_valid;

    int          vectors = 0;
    int          miscompares = 0;
    bit          run_m;
    int          cnt_m [NB];
    bit          prev_m [NB];
    logic [23:0] pcol;
    logic        pval;

    always #5 clk = ~clk;

    brick_field_renderer #(
        .COORD_W(CW), .ROWS(ROWS), .COLS(COLS), .BRICK_W(BW), .BRICK_H(BH),
        .FIELD_X0(FX0), .FIELD_Y0(FY0), .PADDLE_W(PW), .PADDLE_H(PH),
        .BALL_R(BR), .FLASH_FRAMES(FF)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid),
        .x(x), .y(y), .ballx(ballx), .bally(bally),
        .paddlex(paddlex), .paddley(paddley), .hit_mask(hit_mask),
        .color(color), .color_valid(color_valid)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] model_color(input int px, input int py);
        int dx, dy, r, c, i;
        bit fl;
        if (!run_m) return 24'h000000;
        if (px >= int'(paddlex) && px < int'(paddlex) + PW &&
            py >= int'(paddley) && py < int'(paddley) + PH) return 24'hFFFFFF;
        dx = px - int'(ballx); if (dx < 0) dx = -dx;
        dy = py - int'(bally); if (dy < 0) dy = -dy;
        if (dx < BR && dy < BR) return 24'hFFFFFF;
        if (px >= FX0 && py >= FY0) begin
            c = (px - FX0) / BW;
            r = (py - FY0) / BH;
            if (c < int'(COLS) && r < int'(ROWS)) begin
                i  = r * int'(COLS) + c;
                fl = (cnt_m[i] != 0);
                if (!hit_mask[i] || fl) begin
                    if (fl) return 24'hFFFF00;
                    return ((r + c) % 2 == 1) ? 24'hFFFFFF : 24'hFF0000;
                end
            end
        end
        return 24'h000000;
    endfunction

    task automatic model_reset();
        run_m = 1'b0;
        pcol  = 24'h0;
        pval  = 1'b0;
        for (int i = 0; i < int'(NB); i++) begin
            cnt_m[i]  = 0;
            prev_m[i] = 1'b0;
        end
    endtask

    // One pixel clock: predict, advance model state, clock, compare previous prediction.
    task automatic step();
        logic [23:0] ec;
        logic        ev;
        bit          tick;
        ec   = model_color(int'(x), int'(y));
        ev   = pix_valid;
        tick = pix_valid && (x == '0) && (y == '0);
        if (!start) run_m = 1'b1;
`ifdef BRICK_FLASH_EN
        for (int i = 0; i < int'(NB); i++) begin
            if (hit_mask[i] && !prev_m[i])      cnt_m[i] = FF;
            else if (!hit_mask[i] && prev_m[i]) cnt_m[i] = 0;
            else if (tick && cnt_m[i] != 0)     cnt_m[i] = cnt_m[i] - 1;
            prev_m[i] = hit_mask[i];
        end
`else
        if (tick) prev_m[0] = prev_m[0];
`endif
        @(posedge clk);
        @(negedge clk);
        check("color", 32'(color), 32'(pcol));
        check("color_valid", 32'(color_valid), 32'(pval));
        pcol = ec;
        pval = ev;
    endtask

    task automatic drive(input int px, input int py, input logic v);
        x = CW'(px);
        y = CW'(py);
        pix_valid = v;
    endtask

    // Present one pixel, then an idle cycle, then check its colour against a constant.
    task automatic probe(input string tag, input int px, input int py, input logic [23:0] exp);
        drive(px, py, 1'b1);
        step();
        drive(700, 700, 1'b0);
        step();
        check(tag, 32'(color), 32'(exp));
    endtask

    task automatic tick_frame();
        drive(0, 0, 1'b1);
        step();
    endtask

    initial begin
        rst = 1'b0; start = 1'b1; pix_valid = 1'b0;
        x = '0; y = '0;
        ballx = 10'd1020; bally = 10'd1020;
        paddlex = 10'd1000; paddley = 10'd1000;
        hit_mask = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_color", 32'(color), 32'h0);
        check("reset_valid", 32'(color_valid), 32'h0);
        rst = 1'b1;

        // IDLE sweep: outputs must stay black while valid follows input.
        for (int i = 0; i < 30; i++) begin
            drive($urandom_range(0, 639), $urandom_range(0, 479), 1'($urandom_range(0, 1)));
            step();
        end
        probe("idle_brick", 5, 10, 24'h000000);

        start = 1'b0;
        drive(700, 700, 1'b0);
        step();
        start = 1'b1;

        probe("brick01", 85, 10, 24'hFFFFFF);
        probe("brick00", 5, 10, 24'hFF0000);
        probe("backgnd", 640, 400, 24'h000000);

        paddlex = 10'd100; paddley = 10'd400; ballx = 10'd105; bally = 10'd402;
        probe("paddle_over_ball", 105, 402, 24'hFFFFFF);
        paddlex = 10'd1000; paddley = 10'd1000; ballx = 10'd1; bally = 10'd1;
        probe("ball_edge", 0, 0, 24'hFFFFFF);
        ballx = 10'd1020; bally = 10'd1020;

        hit_mask[0] = 1'b1;
        drive(700, 700, 1'b0);
        step();
        probe("flash_load", 5, 10, FLASH_EXP);
        tick_frame();
        probe("flash_tick1", 5, 10, FLASH_EXP);
        tick_frame();
        probe("flash_done", 5, 10, 24'h000000);

        hit_mask[0] = 1'b0;
        drive(700, 700, 1'b0);
        step();
        probe("restored", 5, 10, 24'hFF0000);
        hit_mask[0] = 1'b1;
        tick_frame();
        probe("coinc_flash0", 5, 10, FLASH_EXP);
        tick_frame();
        probe("coinc_flash1", 5, 10, FLASH_EXP);
        tick_frame();
        probe("coinc_done", 5, 10, 24'h000000);

        // Reset in the middle of a flash.
        hit_mask[0] = 1'b0;
        drive(700, 700, 1'b0);
        step();
        hit_mask[0] = 1'b1;
        drive(5, 10, 1'b1);
        step();
        step();
        #2 rst = 1'b0;
        #1;
        check("midrst_color", 32'(color), 32'h0);
        check("midrst_valid", 32'(color_valid), 32'h0);
        hit_mask = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        probe("post_rst_idle", 5, 10, 24'h000000);
        start = 1'b0;
        drive(700, 700, 1'b0);
        step();
        start = 1'b1;
        probe("post_rst_run", 5, 10, 24'hFF0000);

        // Random pixels, objects and hit-mask activity against the model.
        for (int n = 0; n < 3000; n++) begin
            int k;
            if ($urandom_range(0, 63) == 0) drive(0, 0, 1'b1);
            else drive($urandom_range(0, 799), $urandom_range(0, 599), $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) begin
                ballx = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 3)) : CW'($urandom_range(0, 799));
                bally = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 3)) : CW'($urandom_range(0, 599));
            end
            if ($urandom_range(0, 99) == 0) begin
                paddlex = CW'($urandom_range(0, 700));
                paddley = CW'($urandom_range(0, 590));
            end
            if ($urandom_range(0, 39) == 0) begin
                k = $urandom_range(0, NB - 1);
                hit_mask[k] = ~hit_mask[k];
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/brick_field_renderer.md
# brick_field_renderer

Parametrised pixel-colour generator for the Breakout display path: for each pixel coordinate from the VGA timing block it resolves paddle, ball and an arbitrary ROWS×COLS brick grid into a 24-bit RGB colour through a two-stage registered pipeline. It replaces per-brick coordinate ports with a computed grid and a packed hit mask. It adds an optional per-brick "flash" animation on destruction, and sits between the game-logic block (ball, paddle, hit mask) and the VGA output register.

## Interface
- COORD_W, 10, width of all pixel coordinates
- ROWS, 3, brick rows
- COLS, 8, brick columns
- BRICK_W, 80, brick width in pixels
- BRICK_H, 50, brick height in pixels
- FIELD_X0, 0, left edge of brick grid
- FIELD_Y0, 0, top edge of brick grid
- PADDLE_W, 160, paddle width
- PADDLE_H, 10, paddle height
- BALL_R, 3, ball half-size (square)
- FLASH_FRAMES, 8, frames a destroyed brick flashes (1..255)
- clk  in  1  pixel clock
- rst  in  1  asynchronous active-low reset
- start  in  1  active-low start request
- pix_valid  in  1  x/y valid this cycle
- x, y  in  COORD_W  current pixel coordinate
- ballx, bally  in  COORD_W  ball centre
- paddlex, paddley  in  COORD_W  paddle top-left corner
- hit_mask  in  ROWS*COLS  bit r*COLS+c = brick (r,c) destroyed
- color  out  24  RGB888 pixel colour
- color_valid  out  1  color corresponds to pixel presented 2 cycles earlier

## Operation
- FSM states: IDLE, RUN. Reset → IDLE. IDLE→RUN when start==0 is sampled; RUN is held until reset.
- IDLE: the pipeline still runs and color_valid tracks pix_valid; color is forced to 24'h000000.
- RUN hit tests, each true → region active:
  - paddle: paddlex ≤ x < paddlex+PADDLE_W and paddley ≤ y < paddley+PADDLE_H.
  - ball: |x−ballx| < BALL_R and |y−bally| < BALL_R.
  - brick (r,c): FIELD_X0+c·BRICK_W ≤ x < FIELD_X0+(c+1)·BRICK_W, same form in y with r and BRICK_H.
  - Brick (r,c) is drawn when its hit bit is 0, or when it is flashing.
- Arithmetic: all comparisons in COORD_W+2 bits, zero-extended. Sums never wrap and differences never underflow; ballx<BALL_R near the screen edge is legal.
- Priority: paddle > ball > brick > background.
- Colours:
  - paddle and ball: 24'hFFFFFF.
  - brick with (r+c) even: 24'hFF0000; odd: 24'hFFFFFF.
  - flashing brick: 24'hFFFF00.
  - background: 24'h000000.
- Frame tick: pix_valid && x==0 && y==0.

## Timing
- Stage 1 registers all region-hit flags plus the brick index. Stage 2 registers color and color_valid.
- Latency is exactly 2 cycles from pix_valid/x/y to color/color_valid. Throughput is 1 pixel per cycle with no stalls.
- ballx, bally, paddlex, paddley and hit_mask are sampled in stage 1, alongside x/y.
- Reset values: color=0, color_valid=0, FSM=IDLE, pipeline valids=0, flash counters=0.
- Reset asserted mid-frame clears everything asynchronously. The first valid output after release is black until RUN is entered.
- The IDLE→RUN transition affects pixels entering stage 1 on the cycle after start is sampled low.

## Configuration
- BRICK_FLASH_EN defined:
  - Each brick has an 8-bit counter and a registered copy of its hit bit.
  - A 0→1 edge on the hit bit loads FLASH_FRAMES.
  - Each frame tick decrements any nonzero counter.
  - Load and tick in the same cycle: load wins.
  - A 1→0 edge on the hit bit (level reset) clears the counter.
  - A brick is flashing while its counter is nonzero.
- Macro undefined: no counters and no edge registers. A hit brick disappears immediately, and the flash colour is never produced.

## Structure
- Package breakout_pkg: RGB colour constants (BLACK, WHITE, RED, YELLOW), typedef rgb_t [23:0], and the FSM state enum.
- Sub-module brick_flash_timer: one instance per brick, generated under BRICK_FLASH_EN. Ports: clk, rst, hit, frame_tick, flashing.
- The grid hit test is a generate loop in the top module.

## Test plan
- Reset, start held high, sweep pixels → color_valid follows pix_valid with 2-cycle latency, and color is always 0.
- start=0, hit_mask=0, x=85,y=10 → brick (0,1) → 24'hFFFFFF. x=5,y=10 → 24'hFF0000. x=640,y=400 → 0.
- Paddle at (100,400) and ball at (105,402), both overlapping pixel (105,402) → 24'hFFFFFF from paddle, by priority. Ball at (1,1), pixel (0,0) → white, with no underflow miss.
- hit_mask bit 0 set, flash disabled → pixel (5,10) → 24'h000000 on the next frame.
- BRICK_FLASH_EN, FLASH_FRAMES=2: set bit 0 → pixel (5,10) is 24'hFFFF00 for 2 frame ticks, then 24'h000000. A bit rise coinciding with a frame tick still flashes for 2 full frames.
- Assert rst mid-frame while flashing → color 0, color_valid 0 immediately. After release the counters are 0 and the FSM is IDLE.
